fpnew_class_scheduler: RTL and testbench

Shares a single operand classifier among `NumReq` independent requesters, such as per-lane FCLASS issue ports or the compare/min-max pre-stage. A round-robin arbiter selects one valid request per cycle. The block classifies the granted operand and registers a RISC-V 10-bit FCLASS mask together with the requester index and tag. It sits between the operation-group dispatch logic and the FPU result writeback, replacing per-requester classifier copies.

---
 rtl/fpnew_pkg.sv | 84 ++++++++
 rtl/fpnew_classifier.sv | 43 ++++
 rtl/fpnew_class_scheduler.sv | 125 ++++++++++++
 tb/tb_fpnew_class_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpnew_pkg.sv
// Shared FP helpers: formats, classification info and the FCLASS mask layout.
package fpnew_pkg;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  // Per-operand classification flags.
  typedef struct packed {
    logic is_normal;
    logic is_subnormal;
    logic is_zero;
    logic is_inf;
    logic is_nan;
    logic is_signalling;
    logic is_quiet;
    logic is_boxed;
  } fp_info_t;

  // RISC-V FCLASS result, one-hot.
  typedef logic [9:0] fclass_mask_t;

  localparam int unsigned FCLASS_NEG_INF  = 0;
  localparam int unsigned FCLASS_NEG_NORM = 1;
  localparam int unsigned FCLASS_NEG_SUB  = 2;
  localparam int unsigned FCLASS_NEG_ZERO = 3;
  localparam int unsigned FCLASS_POS_ZERO = 4;
  localparam int unsigned FCLASS_POS_SUB  = 5;
  localparam int unsigned FCLASS_POS_NORM = 6;
  localparam int unsigned FCLASS_POS_INF  = 7;
  localparam int unsigned FCLASS_SNAN     = 8;
  localparam int unsigned FCLASS_QNAN     = 9;

  function automatic int unsigned exp_bits(fp_format_e fmt);
    case (fmt)
      FP64:    return 11;
      FP16:    return 5;
      FP8:     return 5;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned man_bits(fp_format_e fmt);
    case (fmt)
      FP64:    return 52;
      FP16:    return 10;
      FP8:     return 2;
      FP16ALT: return 7;
      default: return 23;
    endcase
  endfunction

  function automatic int unsigned fp_width(fp_format_e fmt);
    return 1 + exp_bits(fmt) + man_bits(fmt);
  endfunction

  // Map classifier flags plus sign onto the FCLASS mask; NaNs ignore the sign.
  function automatic fclass_mask_t fclass_mask(fp_info_t info, logic sign);
    fclass_mask_t m;
    m = '0;
    if (info.is_nan) begin
      if (info.is_signalling) m[FCLASS_SNAN] = 1'b1;
      else                    m[FCLASS_QNAN] = 1'b1;
    end else if (info.is_inf) begin
      if (sign) m[FCLASS_NEG_INF] = 1'b1;
      else      m[FCLASS_POS_INF] = 1'b1;
    end else if (info.is_normal) begin
      if (sign) m[FCLASS_NEG_NORM] = 1'b1;
      else      m[FCLASS_POS_NORM] = 1'b1;
    end else if (info.is_subnormal) begin
      if (sign) m[FCLASS_NEG_SUB] = 1'b1;
      else      m[FCLASS_POS_SUB] = 1'b1;
    end else if (info.is_zero && info.is_boxed) begin
      if (sign) m[FCLASS_NEG_ZERO] = 1'b1;
      else      m[FCLASS_POS_ZERO] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/fpnew_classifier.sv
// Combinational operand classifier; a non-boxed operand is reported as quiet NaN.
module fpnew_classifier
  import fpnew_pkg::*;
#(
  parameter fp_format_e  FpFormat    = FP32,
  parameter int unsigned NumOperands = 1,
  localparam int unsigned WIDTH      = fp_width(FpFormat)
) (
  input  logic     [NumOperands-1:0][WIDTH-1:0] operands_i,
  input  logic     [NumOperands-1:0]            is_boxed_i,
  output fp_info_t [NumOperands-1:0]            info_o
);

  localparam int unsigned EXP_BITS = exp_bits(FpFormat);
  localparam int unsigned MAN_BITS = man_bits(FpFormat);

  for (genvar gi = 0; gi < NumOperands; gi++) begin : g_op
    logic [EXP_BITS-1:0] exp_f;
    logic [MAN_BITS-1:0] man_f;
    logic                exp_max, exp_zero, man_zero, boxed;

    assign exp_f    = operands_i[gi][WIDTH-2 -: EXP_BITS];
    assign man_f    = operands_i[gi][MAN_BITS-1:0];
    assign exp_max  = &exp_f;
    assign exp_zero = ~|exp_f;
    assign man_zero = ~|man_f;
    assign boxed    = is_boxed_i[gi];

    // Flag derivation; sign is handled by the consumer.
    always_comb begin
      info_o[gi].is_normal     = boxed & ~exp_zero & ~exp_max;
      info_o[gi].is_subnormal  = boxed & exp_zero & ~man_zero;
      info_o[gi].is_zero       = boxed & exp_zero & man_zero;
      info_o[gi].is_inf        = boxed & exp_max & man_zero;
      info_o[gi].is_nan        = ~boxed | (exp_max & ~man_zero);
      info_o[gi].is_signalling = boxed & exp_max & ~man_zero & ~man_f[MAN_BITS-1];
      info_o[gi].is_quiet      = (~boxed | (exp_max & ~man_zero)) &
                                 ~(boxed & exp_max & ~man_zero & ~man_f[MAN_BITS-1]);
      info_o[gi].is_boxed      = boxed;
    end
  end

endmodule

// File: rtl/fpnew_class_scheduler.sv
// Round-robin arbiter sharing one classifier among NumReq requesters,
// with a single registered FCLASS result stage.
module fpnew_class_scheduler
  import fpnew_pkg::*;
#(
  parameter fp_format_e  FpFormat  = fpnew_pkg::fp_format_e'(0),
  parameter int unsigned NumReq    = 4,
  parameter int unsigned TagWidth  = 5,
  localparam int unsigned WIDTH    = fpnew_pkg::fp_width(FpFormat),
  localparam int unsigned IdxWidth = $clog2(NumReq)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic [NumReq-1:0]                req_valid_i,
  output logic [NumReq-1:0]                req_ready_o,
  input  logic [NumReq-1:0][WIDTH-1:0]     req_operand_i,
  input  logic [NumReq-1:0]                req_is_boxed_i,
  input  logic [NumReq-1:0][TagWidth-1:0]  req_tag_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [9:0]                       out_class_o,
  output logic [IdxWidth-1:0]              out_idx_o,
  output logic [TagWidth-1:0]              out_tag_o
);

  logic [IdxWidth-1:0] ptr_q, ptr_d;
  logic                out_valid_q, out_valid_d;
  fclass_mask_t        out_class_q, out_class_d;
  logic [IdxWidth-1:0] out_idx_q, out_idx_d;
  logic [TagWidth-1:0] out_tag_q, out_tag_d;

  logic                can_accept, grant_found, grant;
  logic [IdxWidth:0]   cand;
  logic [IdxWidth-1:0] grant_idx;
  logic [WIDTH-1:0]    grant_operand;
  logic                grant_boxed;
  logic [TagWidth-1:0] grant_tag;
  fp_info_t            grant_info;
  fclass_mask_t        grant_mask;

  // Stage is free when empty or draining this cycle; flush blocks new work.
  assign can_accept = (!out_valid_q || out_ready_i) && !flush_i;
  assign grant      = can_accept && grant_found;

  // Rotating priority search starting at ptr, wrapping at NumReq.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = {1'b0, ptr_q} + (IdxWidth+1)'(k);
      if (cand >= (IdxWidth+1)'(NumReq)) cand = cand - (IdxWidth+1)'(NumReq);
      if (!grant_found && req_valid_i[cand[IdxWidth-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IdxWidth-1:0];
      end
    end
  end

  // One-hot ready to the granted requester only.
  always_comb begin
    req_ready_o = '0;
    if (grant) req_ready_o[grant_idx] = 1'b1;
  end

  assign grant_operand = req_operand_i[grant_idx];
  assign grant_boxed   = req_is_boxed_i[grant_idx];
  assign grant_tag     = req_tag_i[grant_idx];

  fpnew_classifier #(
    .FpFormat    (FpFormat),
    .NumOperands (1)
  ) i_classifier (
    .operands_i (grant_operand),
    .is_boxed_i (grant_boxed),
    .info_o     (grant_info)
  );

  assign grant_mask = fclass_mask(grant_info, grant_operand[WIDTH-1]);

  // Output stage and pointer next-state; data only loads on a grant.
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    out_idx_d   = out_idx_q;
    out_tag_d   = out_tag_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (can_accept) begin
      out_valid_d = grant;
      if (grant) begin
        out_class_d = grant_mask;
        out_idx_d   = grant_idx;
        out_tag_d   = grant_tag;
        ptr_d       = (grant_idx == IdxWidth'(NumReq-1)) ? '0
                                                         : grant_idx + IdxWidth'(1);
      end
    end
  end

  // State registers with synchronous reset taking priority over flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_idx_q   <= '0;
      out_tag_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_idx_q   <= out_idx_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_class_o = out_class_q;
  assign out_idx_o   = out_idx_q;
  assign out_tag_o   = out_tag_q;

endmodule

// File: tb/tb_fpnew_class_scheduler.sv
// Directed bench: driver pushes hand-computed results, monitor pops on handshake.
module tb_fpnew_class_scheduler;

  localparam int NR = 4;
  localparam int TW = 5;

  logic                   clk = 1'b0;
  logic                   rst_i, flush_i, out_ready_i;
  logic [NR-1:0]          req_valid_i, req_ready_o, req_is_boxed_i;
  logic [NR-1:0][31:0]    req_operand_i;
  logic [NR-1:0][TW-1:0]  req_tag_i;
  logic                   out_valid_o;
  logic [9:0]             out_class_o;
  logic [1:0]             out_idx_o;
  logic [TW-1:0]          out_tag_o;

  fpnew_class_scheduler #(.NumReq(NR), .TagWidth(TW)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_operand_i  (req_operand_i),
    .req_is_boxed_i (req_is_boxed_i),
    .req_tag_i      (req_tag_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_class_o    (out_class_o),
    .out_idx_o      (out_idx_o),
    .out_tag_o      (out_tag_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]    cls;
    logic [1:0]    idx;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic push_exp(input logic [9:0] c, input logic [1:0] i, input logic [TW-1:0] t);
    exp_t e;
    e.cls = c; e.idx = i; e.tag = t;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [31:0] op, input logic b, input logic [TW-1:0] t);
    req_valid_i[i]    = 1'b1;
    req_operand_i[i]  = op;
    req_is_boxed_i[i] = b;
    req_tag_i[i]      = t;
  endtask

  task automatic clr_req();
    req_valid_i = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Check ready mid-cycle, then advance past the next edge.
  task automatic cyc(input string name, input logic [NR-1:0] exp_rdy);
    @(negedge clk);
    chk(name, 32'(req_ready_o), 32'(exp_rdy));
    tick();
  endtask

  // Monitor: every accepted output must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst_i && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_out: got class %h idx %0d tag %0d, expected none",
                 out_class_o, out_idx_o, out_tag_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_class", 32'(out_class_o), 32'(e.cls));
        chk("out_idx",   32'(out_idx_o),   32'(e.idx));
        chk("out_tag",   32'(out_tag_o),   32'(e.tag));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] t2_op  [4];
  logic [9:0]  t2_cls [4];
  logic [31:0] t3_op  [8];
  logic        t3_box [8];
  logic [9:0]  t3_cls [8];

  initial begin
    t2_op  = '{32'h7FC00000, 32'h7F800001, 32'h00000001, 32'h80000000};
    t2_cls = '{10'h200, 10'h100, 10'h020, 10'h008};
    t3_op  = '{32'h3F800000, 32'h3F800000, 32'h807FFFFF, 32'h00000000,
               32'hBF800000, 32'h7F800000, 32'hFFC00001, 32'hFF800001};
    t3_box = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    t3_cls = '{10'h200, 10'h040, 10'h004, 10'h010, 10'h002, 10'h080, 10'h200, 10'h100};

    rst_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b1;
    req_valid_i = '0; req_operand_i = '0; req_is_boxed_i = '0; req_tag_i = '0;
    tick(); tick();
    @(negedge clk);
    chk("rst_valid", 32'(out_valid_o), 0);
    chk("rst_class", 32'(out_class_o), 0);
    chk("rst_idx",   32'(out_idx_o),   0);
    chk("rst_tag",   32'(out_tag_o),   0);
    tick();

    // -inf from requester 0
    rst_i = 1'b0;
    set_req(0, 32'hFF800000, 1'b1, 5'd3);
    push_exp(10'h001, 2'd0, 5'd3);
    cyc("t1_ready", 4'b0001);
    clr_req();
    @(negedge clk);
    chk("t1_valid", 32'(out_valid_o), 1);
    tick();

    // restart pointer at 0, then all four requesters continuously valid
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, t2_op[i], 1'b1, 5'(10 + i));
    for (int k = 0; k < 5; k++) begin
      push_exp(t2_cls[k % 4], 2'(k % 4), 5'(10 + k % 4));
      cyc("t2_ready", 4'(1 << (k % 4)));
    end
    clr_req();

    // single requester 2 streaming operands, first one not boxed
    for (int k = 0; k < 8; k++) begin
      set_req(2, t3_op[k], t3_box[k], 5'(k + 1));
      push_exp(t3_cls[k], 2'd2, 5'(k + 1));
      cyc("t3_ready", 4'b0100);
    end
    clr_req();
    cyc("t3_idle", 4'b0000);

    // backpressure: hold a result while 1 and 3 wait
    out_ready_i = 1'b0;
    set_req(0, 32'h00000000, 1'b1, 5'd5);
    push_exp(10'h010, 2'd0, 5'd5);
    cyc("t4_grant0", 4'b0001);
    clr_req();
    set_req(1, 32'h3F800000, 1'b1, 5'd21);
    set_req(3, 32'hFF800000, 1'b1, 5'd23);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_hold_ready", 32'(req_ready_o), 0);
      chk("t4_hold_valid", 32'(out_valid_o), 1);
      chk("t4_hold_class", 32'(out_class_o), 32'h010);
      chk("t4_hold_idx",   32'(out_idx_o),   0);
      chk("t4_hold_tag",   32'(out_tag_o),   5);
      tick();
    end
    out_ready_i = 1'b1;
    push_exp(10'h040, 2'd1, 5'd21);
    push_exp(10'h001, 2'd3, 5'd23);
    cyc("t4_rel1", 4'b0010);
    cyc("t4_rel3", 4'b1000);
    clr_req();
    cyc("t4_idle", 4'b0000);

    // flush while holding a result; pointer must stay at 3
    out_ready_i = 1'b0;
    set_req(2, 32'h00000000, 1'b1, 5'd6);
    cyc("t5_grant2", 4'b0100);
    clr_req();
    set_req(0, 32'h00000001, 1'b1, 5'd14);
    flush_i = 1'b1;
    @(negedge clk);
    chk("t5_flush_ready", 32'(req_ready_o), 0);
    tick();
    flush_i = 1'b0;
    out_ready_i = 1'b1;
    set_req(3, 32'h80000000, 1'b1, 5'd15);
    @(negedge clk);
    chk("t5_flushed_valid", 32'(out_valid_o), 0);
    chk("t5_ptr_held", 32'(req_ready_o), 32'b1000);
    push_exp(10'h008, 2'd3, 5'd15);
    tick();
    req_valid_i[3] = 1'b0;
    push_exp(10'h020, 2'd0, 5'd14);
    cyc("t5_grant0", 4'b0001);
    clr_req();
    cyc("t5_idle", 4'b0000);

    // reset with a held result and pointer at 2
    out_ready_i = 1'b0;
    set_req(1, 32'h3F800000, 1'b1, 5'd9);
    cyc("t6_grant1", 4'b0010);
    clr_req();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    out_ready_i = 1'b1;
    set_req(0, 32'hFF800000, 1'b1, 5'd1);
    set_req(2, 32'h7F800000, 1'b1, 5'd2);
    @(negedge clk);
    chk("t6_rst_valid", 32'(out_valid_o), 0);
    chk("t6_rst_class", 32'(out_class_o), 0);
    chk("t6_rst_idx",   32'(out_idx_o),   0);
    chk("t6_rst_tag",   32'(out_tag_o),   0);
    chk("t6_ptr0",      32'(req_ready_o), 32'b0001);
    push_exp(10'h001, 2'd0, 5'd1);
    tick();
    req_valid_i[0] = 1'b0;
    push_exp(10'h080, 2'd2, 5'd2);
    cyc("t6_grant2", 4'b0100);
    clr_req();
    cyc("t6_idle", 4'b0000);

    // drain scoreboard with a bounded wait
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    chk("drain_left", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
